// File: rtl/roi_apb_master.sv
// APB3 requester for the ROI register slave: one command per transfer over a
// valid/ready command port, SETUP/ACCESS with wait states and timeout, response on valid/ready.
module roi_apb_master #(
  parameter int APB_DATA_W  = 32,
  parameter int APB_ADDR_W  = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [APB_ADDR_W-1:0] cmd_addr_i,
  input  logic [APB_DATA_W-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [APB_DATA_W-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [APB_ADDR_W-1:0] apb_paddr_o,
  output logic [APB_DATA_W-1:0] apb_pwdata_o,
  output logic                  apb_pwrite_o,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  input  logic [APB_DATA_W-1:0] apb_prdata_i,
  input  logic                  apb_pready_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [APB_ADDR_W-1:0]   paddr_r, paddr_s;
  logic [APB_DATA_W-1:0]   pwdata_r, pwdata_s;
  logic                    pwrite_r, pwrite_s;
  logic                    psel_r, psel_s;
  logic                    penable_r, penable_s;
  logic                    rsp_valid_r, rsp_valid_s;
  logic [APB_DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                    rsp_err_r, rsp_err_s;

  // State register and all registered outputs; async reset drops PSEL/PENABLE at once
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      paddr_r     <= '0;
      pwdata_r    <= '0;
      pwrite_r    <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      paddr_r     <= paddr_s;
      pwdata_r    <= pwdata_s;
      pwrite_r    <= pwrite_s;
      psel_r      <= psel_s;
      penable_r   <= penable_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  // Next-state and next-output decode; every register holds unless its state updates it
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    paddr_s     = paddr_r;
    pwdata_s    = pwdata_r;
    pwrite_s    = pwrite_r;
    psel_s      = psel_r;
    penable_s   = penable_r;
    rsp_valid_s = rsp_valid_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          pwrite_s = cmd_write_i;
          paddr_s  = cmd_addr_i;
          pwdata_s = cmd_write_i ? cmd_wdata_i : '0;
          psel_s   = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        cnt_s     = '0;
        penable_s = 1'b1;
        state_s   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready_i) begin
          rsp_rdata_s = pwrite_r ? '0 : apb_prdata_i;
          rsp_err_s   = 1'b0;
          psel_s      = 1'b0;
          penable_s   = 1'b0;
          pwdata_s    = '0;
          rsp_valid_s = 1'b1;
          state_s     = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          // PREADY never arrived within the window: abort with error
          rsp_rdata_s = '0;
          rsp_err_s   = 1'b1;
          psel_s      = 1'b0;
          penable_s   = 1'b0;
          pwdata_s    = '0;
          rsp_valid_s = 1'b1;
          state_s     = ST_RESP;
        end else begin
          cnt_s       = cnt_r + CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o   = (state_r == ST_IDLE);
  assign busy_o        = (state_r != ST_IDLE);
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rdata_o   = rsp_rdata_r;
  assign rsp_err_o     = rsp_err_r;
  assign apb_paddr_o   = paddr_r;
  assign apb_pwdata_o  = pwdata_r;
  assign apb_pwrite_o  = pwrite_r;
  assign apb_psel_o    = psel_r;
  assign apb_penable_o = penable_r;

endmodule

// File: tb/tb_roi_apb_master.sv
// Randomized self-checking bench for roi_apb_master with a wait-state APB slave
// model and a word-array reference model of the register window.
module tb_roi_apb_master;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int T  = 16;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [AW-1:0] apb_paddr_o;
  logic [DW-1:0] apb_pwdata_o, apb_prdata_i;
  logic          apb_pwrite_o, apb_psel_o, apb_penable_o, apb_pready_i;

  roi_apb_master #(.APB_DATA_W(DW), .APB_ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o),
    .apb_prdata_i(apb_prdata_i), .apb_pready_i(apb_pready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave: PREADY rises on ACCESS cycle number wait_cfg (0-based); noise elsewhere
  logic [31:0] slv_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  int wait_cfg = 0;
  int acc_n = 0;

  initial begin
    apb_pready_i = 1'b0;
    apb_prdata_i = 32'h0;
    for (int i = 0; i < 1024; i++) slv_mem[i] = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!arst_i) begin
        acc_n = 0;
        apb_pready_i = 1'b0;
      end else if (apb_psel_o && apb_penable_o) begin
        if (acc_n == wait_cfg) begin
          apb_pready_i = 1'b1;
          if (apb_pwrite_o) begin
            slv_mem[apb_paddr_o[11:2]] = apb_pwdata_o;
            apb_prdata_i = $urandom;
          end else begin
            apb_prdata_i = slv_mem[apb_paddr_o[11:2]];
          end
        end else begin
          apb_pready_i = 1'b0;
          apb_prdata_i = $urandom;
        end
        acc_n++;
      end else begin
        acc_n = 0;
        apb_pready_i = 1'($urandom_range(0, 1));
        apb_prdata_i = $urandom;
      end
    end
  end

  // One full transfer, entered and left at a falling edge with the DUT idle
  task automatic run_cmd(input logic w, input logic [11:0] a, input logic [31:0] d,
                         input int waits, input int hold, input bit queue,
                         input logic nw, input logic [11:0] na, input logic [31:0] nd);
    logic exp_err;
    logic [31:0] exp_rd;
    int exp_cyc;
    int cyc;
    exp_err = (waits >= T);
    exp_cyc = exp_err ? T : waits + 1;
    exp_rd  = (exp_err || w) ? 32'h0 : ref_mem[a[11:2]];
    if (!exp_err && w) ref_mem[a[11:2]] = d;

    check_val("idle_ready", {31'b0, cmd_ready_o}, 32'd1);
    check_val("idle_busy", {31'b0, busy_o}, 32'd0);
    wait_cfg    = waits;
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_wdata_i = $urandom;
    check_val("setup_psel", {31'b0, apb_psel_o}, 32'd1);
    check_val("setup_penable", {31'b0, apb_penable_o}, 32'd0);
    check_val("setup_paddr", {20'b0, apb_paddr_o}, {20'b0, a});
    check_val("setup_pwrite", {31'b0, apb_pwrite_o}, {31'b0, w});
    check_val("setup_pwdata", apb_pwdata_o, w ? d : 32'h0);
    check_val("setup_ready", {31'b0, cmd_ready_o}, 32'd0);

    cyc = 0;
    @(negedge clk_i);
    while (apb_psel_o && apb_penable_o && cyc < 64) begin
      check_val("acc_paddr", {20'b0, apb_paddr_o}, {20'b0, a});
      check_val("acc_pwdata", apb_pwdata_o, w ? d : 32'h0);
      check_val("acc_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      cyc++;
      @(negedge clk_i);
    end
    check_val("acc_cycles", cyc, exp_cyc);
    check_val("done_psel", {31'b0, apb_psel_o}, 32'd0);
    check_val("done_penable", {31'b0, apb_penable_o}, 32'd0);
    check_val("done_pwdata", apb_pwdata_o, 32'h0);
    check_val("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    check_val("rsp_rdata", rsp_rdata_o, exp_rd);
    check_val("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});

    rsp_ready_i = 1'b0;
    if (queue) begin
      cmd_valid_i = 1'b1;
      cmd_write_i = nw;
      cmd_addr_i  = na;
      cmd_wdata_i = nd;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check_val("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      check_val("hold_rdata", rsp_rdata_o, exp_rd);
      check_val("hold_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
      check_val("hold_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
      check_val("hold_psel", {31'b0, apb_psel_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check_val("hs_valid", {31'b0, rsp_valid_o}, 32'd0);
    check_val("hs_rdata_kept", rsp_rdata_o, exp_rd);
    check_val("hs_err_kept", {31'b0, rsp_err_o}, {31'b0, exp_err});
    check_val("hs_paddr_kept", {20'b0, apb_paddr_o}, {20'b0, a});
    check_val("hs_pwrite_kept", {31'b0, apb_pwrite_o}, {31'b0, w});
    check_val("hs_psel", {31'b0, apb_psel_o}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        cw, nw;
    logic [11:0] ca, na;
    logic [31:0] cd, nd;
    int          r, waits, hold;
    bit          queue;

    arst_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 12'h0; cmd_wdata_i = 32'h0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk_i);
    check_val("rst_psel", {31'b0, apb_psel_o}, 32'd0);
    check_val("rst_penable", {31'b0, apb_penable_o}, 32'd0);
    check_val("rst_paddr", {20'b0, apb_paddr_o}, 32'd0);
    check_val("rst_pwdata", apb_pwdata_o, 32'h0);
    check_val("rst_pwrite", {31'b0, apb_pwrite_o}, 32'd0);
    check_val("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check_val("rst_rdata", rsp_rdata_o, 32'h0);
    check_val("rst_err", {31'b0, rsp_err_o}, 32'd0);
    check_val("rst_busy", {31'b0, busy_o}, 32'd0);
    arst_i = 1'b1;
    @(negedge clk_i);
    check_val("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);

    // Directed cases
    run_cmd(1'b1, 12'h000, 32'h0190012C, 0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b1, 12'h004, 32'h02580190, 0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b0, 12'h004, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b1, 12'h000, 32'h00C800C8, 0, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b0, 12'h000, 32'h0, 3, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b0, 12'h004, 32'h0, 100, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b0, 12'h004, 32'h0, T - 1, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b1, 12'h008, 32'h12345678, T, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b0, 12'h008, 32'h0, 1, 5, 1'b1, 1'b1, 12'h00C, 32'hA5A5_5A5A);
    run_cmd(1'b1, 12'h00C, 32'hA5A5_5A5A, 0, 0, 1'b0, 1'b0, 12'h0, 32'h0);

    // Reset in the middle of a wait-stated ACCESS
    wait_cfg = 100;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 12'h008;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_val("pre_rst_penable", {31'b0, apb_penable_o}, 32'd1);
    #2 arst_i = 1'b0;
    #1;
    check_val("arst_psel", {31'b0, apb_psel_o}, 32'd0);
    check_val("arst_penable", {31'b0, apb_penable_o}, 32'd0);
    check_val("arst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check_val("arst_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk_i);
    arst_i = 1'b1;
    @(negedge clk_i);
    check_val("rel_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    run_cmd(1'b1, 12'h010, 32'hCAFE_F00D, 2, 0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cmd(1'b0, 12'h010, 32'h0, 0, 1, 1'b0, 1'b0, 12'h0, 32'h0);

    // Randomized traffic
    cw = 1'($urandom_range(0, 1));
    ca = 12'($urandom_range(0, 15) << 2);
    cd = $urandom;
    for (int n = 0; n < 60; n++) begin
      nw = 1'($urandom_range(0, 1));
      na = 12'($urandom_range(0, 15) << 2);
      nd = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6)      waits = $urandom_range(0, 3);
      else if (r < 8) waits = $urandom_range(T - 3, T);
      else            waits = T + 5;
      hold  = $urandom_range(0, 3);
      queue = 1'($urandom_range(0, 1));
      run_cmd(cw, ca, cd, waits, hold, queue, nw, na, nd);
      cw = nw; ca = na; cd = nd;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
